sevenseg_scan_ctl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
- Holds NDIG 7-bit digit codes in shadow registers.
- Each slot, presents one digit's code on a shared decoder bus (feeds sevenseg_ext_n input d) and drives the matching active-low anode.
- Inserts a guard (blank) interval between digits to suppress ghosting.
- Applies new digit data only at frame boundaries, so the display never tears.

---
 rtl/sevenseg_pkg.sv | 6 +
 rtl/sevenseg_scan_ctl_timer.sv | 22 ++
 rtl/sevenseg_scan_ctl.sv | 101 ++++++++++
 tb/tb_sevenseg_scan_ctl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared types and constants for the seven-segment scan controller
package sevenseg_pkg;
    localparam int DIG_W = 7;
    typedef enum logic {BLANK, DRIVE} scan_state_t;
    typedef logic [DIG_W-1:0] seg_code_t;
endpackage

// File: rtl/sevenseg_scan_ctl_timer.sv
// scan_timer: self-reloading down-counter with terminal-count flag, shared by guard and drive intervals
module scan_timer #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    // reload with the next interval length on terminal count, otherwise count down
    always_comb begin
        tc    = cnt_q == '0;
        cnt_d = tc ? load_val : cnt_q - W'(1);
    end
    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RST_VAL;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sevenseg_scan_ctl.sv
// sevenseg_scan_ctl: multiplexed seven-segment scan with guard blanking and frame-synchronous updates; SEVENSEG_DIM_EN adds PWM dimming
module sevenseg_scan_ctl
    import sevenseg_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int DIV   = 100000,
    parameter int GUARD = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NDIG*DIG_W-1:0] digits,
    input  logic [NDIG-1:0]       dig_en,
    input  logic                  load,
`ifdef SEVENSEG_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic [DIG_W-1:0]      d_out,
    output logic [NDIG-1:0]       an_n,
    output logic                  frame_done,
    output logic                  pending
);
    localparam int MAXC = DIV > GUARD ? DIV : GUARD;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NDIG);
    localparam logic [CW-1:0] GUARD_LD = CW'(GUARD - 1);
    localparam logic [CW-1:0] DIV_LD   = CW'(DIV - 1);
    localparam logic [IW-1:0] LAST     = IW'(NDIG - 1);

    scan_state_t           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  frame_done_q, frame_done_d;
    logic                  pending_q, pending_d;
    logic [DIG_W-1:0]      d_out_q, d_out_d;
    logic [NDIG-1:0]       an_n_q, an_n_d;
    seg_code_t [NDIG-1:0]  shadow_q, shadow_d;
    seg_code_t [NDIG-1:0]  staging_q, staging_d;
    logic [CW-1:0]         cnt_ld;
    logic                  tc, on, swap;

    scan_timer #(.W(CW), .RST_VAL(GUARD_LD)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_val (cnt_ld),
        .tc       (tc)
    );

`ifdef SEVENSEG_DIM_EN
    logic [3:0] pwm_q;
    // free-running duty counter; the anode is lit while it is at or below the brightness level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= '0;
        else        pwm_q <= pwm_q + 4'd1;
    end
    assign on = pwm_q <= bright;
`else
    assign on = 1'b1;
`endif

    // next-state logic: slot sequencing, frame-boundary swap of staged data, anode and code selection
    always_comb begin
        cnt_ld       = state_q == BLANK ? DIV_LD : GUARD_LD;
        state_d      = tc ? (state_q == BLANK ? DRIVE : BLANK) : state_q;
        idx_d        = (state_q == DRIVE && tc) ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q;
        frame_done_d = state_q == DRIVE && tc && idx_q == LAST;
        swap         = frame_done_q && pending_q;
        pending_d    = load || (pending_q && !frame_done_q);
        staging_d    = load ? digits : staging_q;
        shadow_d     = swap ? staging_q : shadow_q;
        d_out_d      = swap ? staging_q[0] : shadow_q[idx_q];
        for (int i = 0; i < NDIG; i++)
            an_n_d[i] = !(state_q == DRIVE && idx_q == IW'(i) && dig_en[i] && on);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            d_out_q      <= '0;
            an_n_q       <= '1;
            shadow_q     <= '0;
            staging_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            d_out_q      <= d_out_d;
            an_n_q       <= an_n_d;
            shadow_q     <= shadow_d;
            staging_q    <= staging_d;
        end
    end

    assign d_out      = d_out_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;
endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// tb_sevenseg_scan_ctl: directed self-checking bench for sevenseg_scan_ctl (NDIG=4, DIV=4, GUARD=2)
module tb_sevenseg_scan_ctl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] digits = '0;
    logic [3:0]  dig_en = 4'hF;
    logic        load = 1'b0;
    logic [6:0]  d_out;
    logic [3:0]  an_n;
    logic        frame_done, pending;
    int          checks = 0, fails = 0, t = 0;
    logic [3:0]  cur_en = 4'hF;
    int          cur_br = 15;
`ifdef SEVENSEG_DIM_EN
    logic [3:0]  bright = 4'd15;
`endif

    sevenseg_scan_ctl #(.NDIG(4), .DIV(4), .GUARD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dig_en     (dig_en),
        .load       (load),
`ifdef SEVENSEG_DIM_EN
        .bright     (bright),
`endif
        .d_out      (d_out),
        .an_n       (an_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // expected anodes after posedge t: output reflects the slot position of cycle t-1
    function automatic logic [3:0] exp_an(int tt, logic [3:0] en, int br);
        int p;
        p = (tt - 1) % 24;
        if (tt == 0 || p % 6 < 2 || !en[p / 6] || (tt - 1) % 16 > br) return 4'hF;
        return ~(4'b0001 << (p / 6));
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
        t++;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (an_n !== 4'hF) begin fails++; $display("FAIL reset_an_n got %b exp 1111", an_n); end
        checks++; if (d_out !== 7'd0) begin fails++; $display("FAIL reset_d_out got %0d exp 0", d_out); end
        checks++; if (frame_done !== 1'b0 || pending !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b exp 00", frame_done, pending); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_scan();
        digits = {7'd3, 7'd2, 7'd1, 7'd0};
        load = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            step();
            load = 1'b0;
            checks++; if (an_n !== exp_an(t, cur_en, cur_br)) begin fails++; $display("FAIL scan_an_n t=%0d got %b exp %b", t, an_n, exp_an(t, cur_en, cur_br)); end
            checks++; if (d_out !== (t >= 25 ? 7'(((t - 1) % 24) / 6) : 7'd0)) begin fails++; $display("FAIL scan_d_out t=%0d got %0d", t, d_out); end
            checks++; if (frame_done !== (t % 24 == 0)) begin fails++; $display("FAIL scan_frame_done t=%0d got %b", t, frame_done); end
            checks++; if (pending !== (t <= 24)) begin fails++; $display("FAIL scan_pending t=%0d got %b", t, pending); end
        end
    endtask

    task automatic test_dig_en();
        dig_en = 4'b1010;
        cur_en = 4'b1010;
        for (int k = 0; k < 24; k++) begin
            step();
            checks++; if (an_n === 4'b1110 || an_n === 4'b1011 || an_n !== exp_an(t, cur_en, cur_br)) begin fails++; $display("FAIL en_an_n t=%0d got %b exp %b", t, an_n, exp_an(t, cur_en, cur_br)); end
            checks++; if (d_out !== 7'(((t - 1) % 24) / 6)) begin fails++; $display("FAIL en_d_out t=%0d got %0d", t, d_out); end
            checks++; if (frame_done !== (t % 24 == 0)) begin fails++; $display("FAIL en_frame_done t=%0d got %b", t, frame_done); end
        end
    endtask

    task automatic test_double_load();
        while (t < 108) begin
            step();
            load = 1'b0;
            if (t == 75) begin digits = {4{7'd10}}; load = 1'b1; end
            if (t == 80) begin digits = {4{7'd12}}; load = 1'b1; end
            checks++; if (an_n !== exp_an(t, cur_en, cur_br)) begin fails++; $display("FAIL dbl_an_n t=%0d got %b exp %b", t, an_n, exp_an(t, cur_en, cur_br)); end
            checks++; if (d_out !== (t <= 96 ? 7'(((t - 1) % 24) / 6) : 7'd12)) begin fails++; $display("FAIL dbl_d_out t=%0d got %0d", t, d_out); end
            checks++; if (pending !== (t >= 76 && t <= 96)) begin fails++; $display("FAIL dbl_pending t=%0d got %b", t, pending); end
            checks++; if (frame_done !== (t % 24 == 0)) begin fails++; $display("FAIL dbl_frame_done t=%0d got %b", t, frame_done); end
        end
    endtask

    task automatic test_load_boundary();
        while (t < 150) begin
            step();
            load = 1'b0;
            checks++; if (d_out !== (t <= 120 ? 7'd12 : t <= 144 ? 7'd5 : 7'd9)) begin fails++; $display("FAIL bnd_d_out t=%0d got %0d", t, d_out); end
            checks++; if (pending !== (t >= 111 && t <= 144)) begin fails++; $display("FAIL bnd_pending t=%0d got %b", t, pending); end
            checks++; if (frame_done !== (t % 24 == 0)) begin fails++; $display("FAIL bnd_frame_done t=%0d got %b", t, frame_done); end
            checks++; if (an_n !== exp_an(t, cur_en, cur_br)) begin fails++; $display("FAIL bnd_an_n t=%0d got %b exp %b", t, an_n, exp_an(t, cur_en, cur_br)); end
            if (t == 110) begin digits = {4{7'd5}}; load = 1'b1; end
            if (t == 120) begin digits = {4{7'd9}}; load = 1'b1; end
        end
        dig_en = 4'hF;
        cur_en = 4'hF;
    endtask

    task automatic test_async_reset();
        while (t < 160) step();
        checks++; if (an_n !== 4'b1011) begin fails++; $display("FAIL mid_drive_an_n got %b exp 1011", an_n); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (an_n !== 4'hF) begin fails++; $display("FAIL async_an_n got %b exp 1111", an_n); end
        checks++; if (d_out !== 7'd0) begin fails++; $display("FAIL async_d_out got %0d exp 0", d_out); end
        checks++; if (pending !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL async_flags got %b%b exp 00", frame_done, pending); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        t = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (an_n !== exp_an(t, cur_en, cur_br)) begin fails++; $display("FAIL restart_an_n t=%0d got %b exp %b", t, an_n, exp_an(t, cur_en, cur_br)); end
            checks++; if (d_out !== 7'd0 || pending !== 1'b0) begin fails++; $display("FAIL restart_d_out t=%0d got %0d/%b exp 0/0", t, d_out, pending); end
        end
    endtask

`ifdef SEVENSEG_DIM_EN
    task automatic test_dim();
        bright = 4'd3;
        cur_br = 3;
        for (int k = 0; k < 32; k++) begin
            step();
            checks++; if (an_n !== exp_an(t, cur_en, cur_br)) begin fails++; $display("FAIL dim_an_n t=%0d got %b exp %b", t, an_n, exp_an(t, cur_en, cur_br)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_dig_en();
        test_double_load();
        test_load_boundary();
        test_async_reset();
`ifdef SEVENSEG_DIM_EN
        test_dim();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
